debounce_timer_bank: RTL and testbench



---
 rtl/debounce_timer_bank_if.sv | 23 ++
 rtl/debounce_timer_bank.sv | 78 +++++++
 tb/tb_debounce_timer_bank.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_timer_bank_if.sv
// debounce_timer_bank_if: channel timer and threshold-config signals between debouncer FSMs and the shared timer bank.
interface debounce_timer_bank_if #(
    parameter int N_CH   = 4,
    parameter int TICK_W = 8
);
    logic [N_CH-1:0]   timer_reset;
    logic [N_CH-1:0]   timer_done;
    logic              cfg_valid;
    logic [TICK_W-1:0] cfg_hold;
    logic              cfg_ready;
    logic              cfg_applied;
    logic [TICK_W-1:0] hold_active;

    modport master (
        output timer_reset, cfg_valid, cfg_hold,
        input  timer_done, cfg_ready, cfg_applied, hold_active
    );

    modport slave (
        input  timer_reset, cfg_valid, cfg_hold,
        output timer_done, cfg_ready, cfg_applied, hold_active
    );
endinterface

// File: rtl/debounce_timer_bank.sv
// debounce_timer_bank: one shared prescaler plus saturating per-channel tick counters, with a hold threshold swapped only while all channels idle.
// Define DBT_PRESCALE_EN for the PRESCALE-cycle tick; otherwise counts advance every clock.
module debounce_timer_bank #(
`ifdef DBT_PRESCALE_EN
    parameter int PRESCALE     = 1000,
`endif
    parameter int N_CH         = 4,
    parameter int TICK_W       = 8,
    parameter int HOLD_DEFAULT = 10
) (
    input logic                  clk,
    input logic                  reset_n,
    debounce_timer_bank_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PEND, APPLY} state_t;

    state_t            r_state, w_next;
    logic [TICK_W-1:0] r_count [N_CH];
    logic [TICK_W-1:0] r_hold, r_pend;
    logic              w_tick;

`ifdef DBT_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    logic [PW-1:0] r_pre;

    // free-running: channel activity never realigns the tick phase
    assign w_tick = r_pre == PW'(PRESCALE - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_pre <= '0;
        else          r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) r_count[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.timer_reset[i])                  r_count[i] <= '0;
                else if (w_tick && r_count[i] < r_hold) r_count[i] <= r_count[i] + 1'b1;
            end
        end
    end

    always_comb begin
        bus.timer_done = '0;
        for (int i = 0; i < N_CH; i++) bus.timer_done[i] = r_count[i] >= r_hold;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_hold  <= TICK_W'(HOLD_DEFAULT);
            r_pend  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.cfg_valid) r_pend <= bus.cfg_hold;
            if (r_state == APPLY)                 r_hold <= r_pend;
        end
    end

    // the swap waits for every channel to be idle so no timing in flight sees a threshold change
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = bus.cfg_valid ? PEND : IDLE;
            PEND:    w_next = &bus.timer_reset ? APPLY : PEND;
            default: w_next = IDLE;
        endcase
        bus.cfg_ready   = r_state == IDLE;
        bus.cfg_applied = r_state == APPLY;
    end

    assign bus.hold_active = r_hold;
endmodule

// File: tb/tb_debounce_timer_bank.sv
// tb_debounce_timer_bank: scoreboard bench for debounce_timer_bank; tick period follows DBT_PRESCALE_EN.
`timescale 1ns/1ps
module tb_debounce_timer_bank;
    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 3;
`ifdef DBT_PRESCALE_EN
    localparam int P = 4;
`else
    localparam int P = 1;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];

    debounce_timer_bank_if #(.N_CH(N), .TICK_W(W)) bus ();

    debounce_timer_bank #(
`ifdef DBT_PRESCALE_EN
        .PRESCALE(P),
`endif
        .N_CH(N),
        .TICK_W(W),
        .HOLD_DEFAULT(H)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // edges since reset release; a tick lands on every edge where cyc % P == 0
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic void expect_(input string name, input logic [31:0] val);
        sb.push_back('{name, val});
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic time_channel(input int ch, input int h, output logic [31:0] lat);
        int k, rise;
        k    = cyc + 1;
        rise = k + (P - k % P) % P + (h - 1) * P;
        expect_($sformatf("latency_ch%0d_hold%0d", ch, h), 32'(rise - k + 1));
        bus.timer_reset[ch] = 1'b0;
        lat = '1;
        for (int n = 1; n <= (h + 1) * P + 5; n++) begin
            step(1);
            if (bus.timer_done[ch] === 1'b1) begin
                lat = 32'(n);
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] act[$];
        exp_t e;
        reset_n = 1'b0;
        bus.timer_reset = '1;
        bus.cfg_valid = 1'b0;
        bus.cfg_hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step(1);
        expect_("reset_timer_done", 32'h0);  act.push_back(32'(bus.timer_done));
        expect_("reset_hold_active", 32'(H)); act.push_back(32'(bus.hold_active));
        expect_("reset_cfg_ready", 32'h1);    act.push_back(32'(bus.cfg_ready));
        expect_("reset_cfg_applied", 32'h0);  act.push_back(32'(bus.cfg_applied));
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    task automatic test_hold_timing();
        logic [31:0] act[$];
        logic [31:0] lat;
        exp_t e;
        step(8);
        time_channel(0, H, lat);
        act.push_back(lat);
        expect_("others_low_at_rise", 32'h0); act.push_back(32'(bus.timer_done[3:1]));
        step(3);
        expect_("done0_stays_high", 32'h1); act.push_back(32'(bus.timer_done[0]));
        bus.timer_reset[0] = 1'b1;
        step(1);
        expect_("done0_cleared", 32'h0); act.push_back(32'(bus.timer_done[0]));
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    task automatic test_short_pulse();
        logic [31:0] act[$];
        logic [31:0] lat;
        logic seen;
        int len;
        exp_t e;
        len  = (H - 1) * P < 5 ? (H - 1) * P : 5;
        seen = 1'b0;
        bus.timer_reset[1] = 1'b0;
        repeat (len) begin
            step(1);
            seen = seen | bus.timer_done[1];
        end
        bus.timer_reset[1] = 1'b1;
        step(1);
        seen = seen | bus.timer_done[1];
        expect_("short_pulse_no_done", 32'h0); act.push_back(32'(seen));
        step(H * P + 2);
        expect_("short_pulse_idle_low", 32'h0); act.push_back(32'(bus.timer_done[1]));
        time_channel(1, H, lat);
        act.push_back(lat);
        bus.timer_reset[1] = 1'b1;
        step(1);
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    task automatic test_cfg_pend();
        logic [31:0] act[$];
        logic [31:0] lat;
        logic applied_seen;
        exp_t e;
        bus.timer_reset[2] = 1'b0;
        bus.cfg_hold = 8'd5;
        bus.cfg_valid = 1'b1;
        step(1);
        expect_("pend_ready_low", 32'h0); act.push_back(32'(bus.cfg_ready));
        bus.cfg_hold = 8'd9;
        applied_seen = 1'b0;
        repeat (4) begin
            step(1);
            applied_seen = applied_seen | bus.cfg_applied;
        end
        bus.cfg_valid = 1'b0;
        expect_("pend_ready_still_low", 32'h0); act.push_back(32'(bus.cfg_ready));
        expect_("pend_no_apply", 32'h0);        act.push_back(32'(applied_seen));
        expect_("pend_hold_unchanged", 32'(H)); act.push_back(32'(bus.hold_active));
        bus.timer_reset[2] = 1'b1;
        step(1);
        expect_("apply_pulse", 32'h1);          act.push_back(32'(bus.cfg_applied));
        expect_("apply_hold_not_yet", 32'(H));  act.push_back(32'(bus.hold_active));
        step(1);
        expect_("after_apply_pulse_gone", 32'h0); act.push_back(32'(bus.cfg_applied));
        expect_("after_apply_hold", 32'd5);       act.push_back(32'(bus.hold_active));
        expect_("after_apply_ready", 32'h1);      act.push_back(32'(bus.cfg_ready));
        time_channel(3, 5, lat);
        act.push_back(lat);
        bus.timer_reset[3] = 1'b1;
        step(1);
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    task automatic test_hold_zero();
        logic [31:0] act[$];
        exp_t e;
        bus.cfg_hold = '0;
        bus.cfg_valid = 1'b1;
        step(1);
        bus.cfg_valid = 1'b0;
        step(1);
        expect_("zero_apply_pulse", 32'h1); act.push_back(32'(bus.cfg_applied));
        step(1);
        expect_("zero_hold_active", 32'h0); act.push_back(32'(bus.hold_active));
        expect_("zero_all_done", 32'hf);    act.push_back(32'(bus.timer_done));
        bus.timer_reset[0] = 1'b0;
        step(1);
        expect_("zero_done_while_active", 32'hf); act.push_back(32'(bus.timer_done));
        bus.timer_reset[0] = 1'b1;
        step(1);
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        logic [31:0] act[$];
        logic applied_seen;
        exp_t e;
        bus.timer_reset[0] = 1'b0;
        bus.cfg_hold = 8'd7;
        bus.cfg_valid = 1'b1;
        step(1);
        bus.cfg_valid = 1'b0;
        expect_("midpend_ready_low", 32'h0); act.push_back(32'(bus.cfg_ready));
        step(2);
        #2 reset_n = 1'b0;
        #1;
        expect_("midpend_reset_hold", 32'(H));  act.push_back(32'(bus.hold_active));
        expect_("midpend_reset_ready", 32'h1);  act.push_back(32'(bus.cfg_ready));
        expect_("midpend_reset_done", 32'h0);   act.push_back(32'(bus.timer_done));
        bus.timer_reset = '1;
        @(negedge clk) reset_n = 1'b1;
        applied_seen = 1'b0;
        repeat (6) begin
            step(1);
            applied_seen = applied_seen | bus.cfg_applied;
        end
        expect_("midpend_no_apply", 32'h0);    act.push_back(32'(applied_seen));
        expect_("midpend_hold_kept", 32'(H));  act.push_back(32'(bus.hold_active));
        foreach (act[i]) begin
            e = sb.pop_front();
            n_tests++;
            if (act[i] !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act[i], e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hold_timing();
        test_short_pulse();
        test_cfg_pend();
        test_hold_zero();
        test_reset_mid_pend();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
